// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM bus widths, bus state encoding and arbitration polarity
package vram_pkg;
   localparam int VRAM_ADDR_W = 20;
   localparam int VRAM_DATA_W = 16;
   localparam logic BUS_FREE = 1'b0;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} vram_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous first-word-fall-through FIFO, push and pop may coincide when full
module sync_fifo #(
   parameter int W = 36,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic wr_en, rd_en;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign dout = mem_q[rd_q];
   // next pointers and occupancy; a pop frees the slot a simultaneous push needs
   always_comb begin
      rd_en = pop & ~empty;
      wr_en = push & (~full | rd_en);
      wr_d = wr_q + AW'(wr_en);
      rd_d = rd_q + AW'(rd_en);
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
   end
   // pointer/count registers and storage write
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
      if (wr_en) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/vram_write_queue.sv
// vram_write_queue: queues host writes and drains them into the VRAM with WE-controlled cycles
module vram_write_queue
   import vram_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WE_CYCLES = 2
) (
   input  logic                   clock,
   input  logic                   RESET,
   input  logic                   hostWrite,
   input  logic [VRAM_ADDR_W-1:0] hostAddress,
   input  logic [VRAM_DATA_W-1:0] hostData,
   output logic                   hostFull,
   output logic                   empty,
   output logic                   overflow,
   output logic [7:0]             dropCount,
   input  logic [VRAM_ADDR_W-1:0] maxVramAddress,
   input  logic                   bus_free,
   output logic                   busy,
   output logic [VRAM_ADDR_W-1:0] vramAddress,
   output logic [VRAM_DATA_W-1:0] vramDataOut,
   output logic                   dataDrive,
   output logic                   writeSignal,
   output logic                   chipEnable
);
   localparam int CW = WE_CYCLES > 1 ? $clog2(WE_CYCLES) : 1;
   localparam int FW = VRAM_ADDR_W + VRAM_DATA_W;
   vram_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VRAM_ADDR_W-1:0] addr_q, addr_d, head_addr;
   logic [VRAM_DATA_W-1:0] data_q, data_d;
   logic [7:0] drop_q, drop_d;
   logic ovf_q, ovf_d, we_q, we_d, ce_q, ce_d, own_q, own_d;
   logic [FW-1:0] head;
   logic fifo_empty, fifo_full, pop;
   sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk(clock),
      .rst(RESET),
      .push(hostWrite & ~fifo_full),
      .pop(pop),
      .din({hostAddress, hostData}),
      .dout(head),
      .full(fifo_full),
      .empty(fifo_empty)
   );
   assign head_addr = head[FW-1:VRAM_DATA_W] & {{(VRAM_ADDR_W-1){1'b1}}, 1'b0};
   assign hostFull = fifo_full;
   assign empty = fifo_empty;
   assign overflow = ovf_q;
   assign dropCount = drop_q;
   assign busy = own_q;
   assign dataDrive = own_q;
   assign vramAddress = addr_q;
   assign vramDataOut = data_q;
   assign writeSignal = we_q;
   assign chipEnable = ce_q;
   // write-cycle sequencing, range drops, and pin levels decoded from the next state
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      addr_d = addr_q;
      data_d = data_q;
      drop_d = drop_q;
      pop = 1'b0;
      ovf_d = ovf_q | (hostWrite & fifo_full);
      case (state_q)
         IDLE:
            if (!fifo_empty) begin
               if (head_addr > maxVramAddress) begin
                  pop = 1'b1;
                  drop_d = drop_q + {7'd0, drop_q != 8'hFF};
               end else if (bus_free == BUS_FREE) begin
                  addr_d = head_addr;
                  data_d = head[VRAM_DATA_W-1:0];
                  state_d = SETUP;
               end
            end
         SETUP:
            if (bus_free != BUS_FREE) state_d = IDLE;
            else begin
               state_d = STROBE;
               cnt_d = CW'(WE_CYCLES - 1);
               pop = 1'b1;
            end
         STROBE:
            if (cnt_q == '0) state_d = HOLD;
            else cnt_d = cnt_q - 1'b1;
         HOLD: state_d = IDLE;
      endcase
      we_d = state_d != STROBE;
      ce_d = state_d == IDLE;
      own_d = state_d != IDLE;
   end
   // state, latched write and registered pin outputs
   always_ff @(posedge clock) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q <= '0;
         addr_q <= '0;
         data_q <= '0;
         drop_q <= '0;
         ovf_q <= 1'b0;
         we_q <= 1'b1;
         ce_q <= 1'b1;
         own_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         data_q <= data_d;
         drop_q <= drop_d;
         ovf_q <= ovf_d;
         we_q <= we_d;
         ce_q <= ce_d;
         own_q <= own_d;
      end
   end
endmodule

// File: tb/tb_vram_write_queue.sv
// tb_vram_write_queue: directed scoreboard bench for the VRAM write queue
module tb_vram_write_queue;
   logic clock = 1'b0;
   logic RESET = 1'b1;
   logic hostWrite = 1'b0;
   logic [19:0] hostAddress = '0;
   logic [15:0] hostData = '0;
   logic [19:0] maxVramAddress = 20'hFFFFF;
   logic bus_free = 1'b0;
   logic hostFull, empty, overflow, busy, dataDrive, writeSignal, chipEnable;
   logic [7:0] dropCount;
   logic [19:0] vramAddress;
   logic [15:0] vramDataOut;
   int n_cmp = 0;
   int n_err = 0;
   logic [35:0] exp_q [$];
   logic [35:0] e;
   logic [19:0] cap_addr;
   int we_run = 0;
   logic [14:0] pat;
   bit saw_ce;

   vram_write_queue #(.DEPTH(8), .WE_CYCLES(2)) dut (
      .clock(clock),
      .RESET(RESET),
      .hostWrite(hostWrite),
      .hostAddress(hostAddress),
      .hostData(hostData),
      .hostFull(hostFull),
      .empty(empty),
      .overflow(overflow),
      .dropCount(dropCount),
      .maxVramAddress(maxVramAddress),
      .bus_free(bus_free),
      .busy(busy),
      .vramAddress(vramAddress),
      .vramDataOut(vramDataOut),
      .dataDrive(dataDrive),
      .writeSignal(writeSignal),
      .chipEnable(chipEnable)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [19:0] a, input logic [15:0] d, input bit keep);
      hostWrite = 1'b1;
      hostAddress = a;
      hostData = d;
      if (keep) exp_q.push_back({a & 20'hFFFFE, d});
      tick(1);
      hostWrite = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (!(empty && !busy) && k < lim) begin
         tick(1);
         k++;
      end
      check("drain_bound", 32'(k < lim), 1);
   endtask

   // monitor: every completed WE pulse is one write, compared against the scoreboard head
   always @(negedge clock) begin
      if (RESET) we_run = 0;
      else if (!writeSignal) begin
         check("we_ctrl", {30'd0, chipEnable, dataDrive}, 1);
         if (we_run == 0) cap_addr = vramAddress;
         we_run++;
      end else if (we_run != 0) begin
         check("hold_ctrl", {30'd0, chipEnable, dataDrive}, 1);
         check("addr_stable", vramAddress, cap_addr);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", vramAddress, vramDataOut);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", vramAddress, e[35:16]);
            check("wr_data", vramDataOut, e[15:0]);
         end
         check("we_len", we_run, 2);
         we_run = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      RESET = 1'b0;
      check("rst_we", writeSignal, 1);
      check("rst_ce", chipEnable, 1);
      check("rst_drv", dataDrive, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", vramAddress, 0);
      check("rst_data", vramDataOut, 0);
      check("rst_full", hostFull, 0);
      check("rst_empty", empty, 1);
      check("rst_ovf", overflow, 0);
      check("rst_drop", dropCount, 0);

      // single write timing
      push(20'h00123, 16'hF800, 1);
      check("t1_nonempty", empty, 0);
      check("t1_ce_idle", chipEnable, 1);
      tick(1);
      check("t1_setup_ce", chipEnable, 0);
      check("t1_setup_we", writeSignal, 1);
      check("t1_setup_busy", busy, 1);
      check("t1_setup_addr", vramAddress, 20'h00122);
      check("t1_setup_data", vramDataOut, 16'hF800);
      tick(1);
      check("t1_strobe1_we", writeSignal, 0);
      tick(1);
      check("t1_strobe2_we", writeSignal, 0);
      tick(1);
      check("t1_hold", {29'd0, writeSignal, chipEnable, dataDrive}, 3'b101);
      tick(1);
      check("t1_idle", {29'd0, chipEnable, dataDrive, busy}, 3'b100);
      check("t1_empty", empty, 1);

      // arbitration: held off, then back-to-back with one idle gap
      bus_free = 1'b1;
      push(20'h00200, 16'h1111, 1);
      push(20'h00400, 16'h2222, 1);
      push(20'h00600, 16'h3333, 1);
      saw_ce = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (!chipEnable) saw_ce = 1;
      end
      check("t2_held_off", 32'(saw_ce), 0);
      bus_free = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         pat = {pat[13:0], busy};
      end
      check("t2_busy_pattern", 32'(pat), 32'(15'b111101111011110));
      wait_idle(20);

      // abort in SETUP, then bus_free ignored in STROBE
      push(20'h04444, 16'h1234, 1);
      tick(1);
      check("t3_setup", chipEnable, 0);
      bus_free = 1'b1;
      tick(1);
      check("t3_abort", {29'd0, chipEnable, dataDrive, empty}, 3'b100);
      tick(2);
      check("t3_still_held", chipEnable, 1);
      bus_free = 1'b0;
      tick(1);
      check("t3_resetup", chipEnable, 0);
      tick(1);
      check("t3_strobe1", writeSignal, 0);
      bus_free = 1'b1;
      tick(1);
      check("t3_strobe2", writeSignal, 0);
      tick(1);
      check("t3_hold", {30'd0, writeSignal, chipEnable}, 2'b10);
      bus_free = 1'b0;
      wait_idle(20);

      // overflow
      bus_free = 1'b1;
      for (int i = 0; i < 7; i++) push(20'(32'h01000 + i * 2), 16'(32'hA000 + i), 1);
      check("t4_not_full", hostFull, 0);
      push(20'h0100E, 16'hA007, 1);
      check("t4_full", hostFull, 1);
      push(20'h01010, 16'hA008, 0);
      check("t4_ovf", overflow, 1);
      check("t4_still_full", hostFull, 1);
      bus_free = 1'b0;
      wait_idle(200);
      check("t4_drained", empty, 1);
      check("t4_ovf_sticky", overflow, 1);

      // address range and drop saturation
      maxVramAddress = 20'h0FFFE;
      push(20'h0FFFE, 16'h5555, 1);
      push(20'h10000, 16'h6666, 0);
      push(20'h0FFFF, 16'h7777, 1);
      wait_idle(50);
      check("t5_drop1", dropCount, 1);
      for (int i = 0; i < 300; i++) push(20'h20000, 16'(i), 0);
      wait_idle(50);
      check("t5_drop_sat", dropCount, 8'hFF);

      // reset during STROBE
      maxVramAddress = 20'hFFFFF;
      bus_free = 1'b1;
      push(20'h08000, 16'h0001, 1);
      push(20'h08002, 16'h0002, 1);
      push(20'h08004, 16'h0003, 1);
      bus_free = 1'b0;
      for (int k = 0; k < 20 && writeSignal; k++) tick(1);
      check("t6_in_strobe", writeSignal, 0);
      RESET = 1'b1;
      exp_q.delete();
      tick(1);
      RESET = 1'b0;
      check("t6_rst_ctrl", {29'd0, writeSignal, chipEnable, dataDrive}, 3'b110);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_flags", {23'd0, overflow, dropCount}, 0);
      tick(10);
      check("t6_quiet", {30'd0, busy, chipEnable}, 2'b01);

      check("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
